// File: rtl/apb_uart_pkg.sv
// Shared register map, bit positions and state encodings for the APB UART.
package apb_uart_pkg;

  // Register index = PADDR[4:2]
  localparam logic [2:0] REG_DATA   = 3'd0;
  localparam logic [2:0] REG_STAT   = 3'd1;
  localparam logic [2:0] REG_CTRL   = 3'd2;
  localparam logic [2:0] REG_DIV    = 3'd3;
  localparam logic [2:0] REG_IRQ_EN = 3'd4;
  localparam logic [2:0] REG_RX_THR = 3'd5;

  localparam int unsigned STAT_TXFULL    = 0;
  localparam int unsigned STAT_TXEMPTY   = 1;
  localparam int unsigned STAT_RXFULL    = 2;
  localparam int unsigned STAT_RXEMPTY   = 3;
  localparam int unsigned STAT_OVERRUN   = 4;
  localparam int unsigned STAT_PARITY    = 5;
  localparam int unsigned STAT_FRAME     = 6;
  localparam int unsigned STAT_TXBUSY    = 7;
  localparam int unsigned STAT_RXLVL_LSB = 8;

  localparam int unsigned CTRL_TX_EN    = 0;
  localparam int unsigned CTRL_RX_EN    = 1;
  localparam int unsigned CTRL_PAR_LSB  = 2;
  localparam int unsigned CTRL_TWO_STOP = 4;

  localparam int unsigned IRQ_RX_THR   = 0;
  localparam int unsigned IRQ_TX_EMPTY = 1;
  localparam int unsigned IRQ_ERR      = 2;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } parity_e;

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP1, TX_STOP2
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP
  } rx_state_e;

  function automatic logic parity_on(input parity_e p);
    return (p == PAR_EVEN) || (p == PAR_ODD);
  endfunction

  function automatic logic parity_bit(input logic [7:0] d, input parity_e p);
    return (^d) ^ (p == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO; a pop on empty is ignored, a push on full is accepted
// only when a pop frees the slot in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(Depth):0]   level
);
  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (level == '0);
  assign full    = level[AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/apb_uart_fifo.sv
// APB3 UART: register file, TX/RX FIFOs, TX and RX framing FSMs, level IRQ.
module apb_uart_fifo
  import apb_uart_pkg::*;
#(
  parameter int unsigned ApbAddrWidth = 32,
  parameter int unsigned ApbDataWidth = 32,
  parameter int unsigned TxFifoDepth  = 16,
  parameter int unsigned RxFifoDepth  = 16,
  parameter logic [15:0] DefaultDiv   = 16'd86
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [ApbAddrWidth-1:0] PADDR,
  input  logic [ApbDataWidth-1:0] PWDATA,
  input  logic                    PWRITE,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  output logic [ApbDataWidth-1:0] PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic                    rx_i,
  output logic                    tx_o,
  output logic                    event_o
);
  logic [4:0]  ctrl;
  logic [15:0] div;
  logic [2:0]  irq_en;
  logic [7:0]  rx_thr;
  logic        overrun, parity_err, frame_err;

  logic        access, mapped, err, is_data;
  logic [2:0]  addr;
  logic        unused_ok;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_rdata;
  logic [$clog2(TxFifoDepth):0] tx_level;
  logic        rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_rdata;
  logic [$clog2(RxFifoDepth):0] rx_level;
  logic [7:0]  rx_level8, thr_eff;
  logic [15:0] stat;

  tx_state_e   tx_state;
  logic [15:0] tx_cnt, tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_par_on, tx_par_val, tx_two, tx_tick, tx_busy;

  rx_state_e   rx_state;
  logic [1:0]  rx_sync;
  logic        rx_s, rx_d;
  logic [15:0] rx_cnt, rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  parity_e     rx_par;
  logic        rx_par_bad, rx_tick, rx_half, rx_par_mis, stop_tick;
  logic        ovr_set, par_set, frm_set, irq_next;

  assign unused_ok = ^{PADDR, PWDATA, tx_level};

  assign PREADY  = 1'b1;
  assign access  = PSEL & PENABLE;
  assign addr    = PADDR[4:2];
  assign mapped  = (addr <= REG_RX_THR);
  assign is_data = (addr == REG_DATA);
  assign err     = access & (~mapped | (is_data & PWRITE & tx_full)
                                     | (is_data & ~PWRITE & rx_empty));
  assign PSLVERR = err;
  assign tx_push = access & PWRITE & is_data & ~tx_full;
  assign rx_pop  = access & ~PWRITE & is_data & ~rx_empty;

  assign tx_busy   = (tx_state != TX_IDLE);
  assign rx_level8 = 8'(rx_level);
  assign thr_eff   = (rx_thr == 8'd0) ? 8'd1 : rx_thr;

  always_comb begin
    stat = '0;
    stat[STAT_TXFULL]  = tx_full;
    stat[STAT_TXEMPTY] = tx_empty;
    stat[STAT_RXFULL]  = rx_full;
    stat[STAT_RXEMPTY] = rx_empty;
    stat[STAT_OVERRUN] = overrun;
    stat[STAT_PARITY]  = parity_err;
    stat[STAT_FRAME]   = frame_err;
    stat[STAT_TXBUSY]  = tx_busy;
    stat[STAT_RXLVL_LSB +: 8] = rx_level8;
  end

  always_comb begin
    PRDATA = '0;
    if (access & ~PWRITE & ~err) begin
      case (addr)
        REG_DATA:   PRDATA[7:0]  = rx_rdata;
        REG_STAT:   PRDATA[15:0] = stat;
        REG_CTRL:   PRDATA[4:0]  = ctrl;
        REG_DIV:    PRDATA[15:0] = div;
        REG_IRQ_EN: PRDATA[2:0]  = irq_en;
        REG_RX_THR: PRDATA[7:0]  = rx_thr;
        default:    PRDATA       = '0;
      endcase
    end
  end

  assign irq_next = (irq_en[IRQ_RX_THR]   & (rx_level8 >= thr_eff))
                  | (irq_en[IRQ_TX_EMPTY] & tx_empty & ~tx_busy)
                  | (irq_en[IRQ_ERR]      & (overrun | parity_err | frame_err));

  // Flag set pulses are applied after STAT clears so a coincident event is not lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ctrl       <= '0;
      div        <= DefaultDiv;
      irq_en     <= '0;
      rx_thr     <= 8'd1;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      event_o    <= 1'b0;
    end else begin
      if (access & PWRITE & ~err) begin
        case (addr)
          REG_STAT: begin
            if (PWDATA[STAT_OVERRUN]) overrun    <= 1'b0;
            if (PWDATA[STAT_PARITY])  parity_err <= 1'b0;
            if (PWDATA[STAT_FRAME])   frame_err  <= 1'b0;
          end
          REG_CTRL:   ctrl   <= PWDATA[4:0];
          REG_DIV:    div    <= PWDATA[15:0];
          REG_IRQ_EN: irq_en <= PWDATA[2:0];
          REG_RX_THR: rx_thr <= PWDATA[7:0];
          default: ;
        endcase
      end
      if (ovr_set) overrun    <= 1'b1;
      if (par_set) parity_err <= 1'b1;
      if (frm_set) frame_err  <= 1'b1;
      event_o <= irq_next;
    end
  end

  uart_sync_fifo #(.Width(8), .Depth(TxFifoDepth)) u_tx_fifo (
    .clk(CLK), .rst(RST), .push(tx_push), .pop(tx_pop), .wdata(PWDATA[7:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty), .level(tx_level)
  );

  uart_sync_fifo #(.Width(8), .Depth(RxFifoDepth)) u_rx_fifo (
    .clk(CLK), .rst(RST), .push(rx_push), .pop(rx_pop), .wdata(rx_shift),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty), .level(rx_level)
  );

  assign tx_pop  = (tx_state == TX_IDLE) & ctrl[CTRL_TX_EN] & ~tx_empty;
  assign tx_tick = (tx_cnt == tx_div);

  always_ff @(posedge CLK) begin
    if (RST) begin
      tx_state   <= TX_IDLE;
      tx_o       <= 1'b1;
      tx_cnt     <= '0;
      tx_div     <= '0;
      tx_shift   <= '0;
      tx_bit     <= '0;
      tx_par_on  <= 1'b0;
      tx_par_val <= 1'b0;
      tx_two     <= 1'b0;
    end else if (tx_state == TX_IDLE) begin
      tx_o <= 1'b1;
      if (tx_pop) begin
        tx_shift   <= tx_rdata;
        tx_div     <= div;
        tx_par_on  <= parity_on(parity_e'(ctrl[CTRL_PAR_LSB +: 2]));
        tx_par_val <= parity_bit(tx_rdata, parity_e'(ctrl[CTRL_PAR_LSB +: 2]));
        tx_two     <= ctrl[CTRL_TWO_STOP];
        tx_cnt     <= '0;
        tx_state   <= TX_START;
        tx_o       <= 1'b0;
      end
    end else if (!tx_tick) begin
      tx_cnt <= tx_cnt + 1'b1;
    end else begin
      tx_cnt <= '0;
      case (tx_state)
        TX_START: begin
          tx_state <= TX_DATA;
          tx_bit   <= '0;
          tx_o     <= tx_shift[0];
        end
        TX_DATA: begin
          if (tx_bit == 3'd7) begin
            tx_state <= tx_par_on ? TX_PARITY : TX_STOP1;
            tx_o     <= tx_par_on ? tx_par_val : 1'b1;
          end else begin
            tx_bit   <= tx_bit + 1'b1;
            tx_shift <= tx_shift >> 1;
            tx_o     <= tx_shift[1];
          end
        end
        TX_PARITY: begin
          tx_state <= TX_STOP1;
          tx_o     <= 1'b1;
        end
        TX_STOP1: tx_state <= tx_two ? TX_STOP2 : TX_IDLE;
        default:  tx_state <= TX_IDLE;
      endcase
    end
  end

  assign rx_s       = rx_sync[1];
  assign rx_tick    = (rx_cnt == rx_div);
  assign rx_half    = (17'(rx_cnt) + 17'd1) >= ((17'(rx_div) + 17'd1) >> 1);
  assign rx_par_mis = (rx_s != parity_bit(rx_shift, rx_par));
  assign stop_tick  = (rx_state == RX_STOP) & rx_tick;
  assign par_set    = (rx_state == RX_PARITY) & rx_tick & rx_par_mis;
  assign frm_set    = stop_tick & ~rx_s;
  assign ovr_set    = stop_tick & rx_s & ~rx_par_bad & rx_full;
  assign rx_push    = stop_tick & rx_s & ~rx_par_bad & ~rx_full;

  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_sync    <= 2'b11;
      rx_d       <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= '0;
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_par     <= PAR_NONE;
      rx_par_bad <= 1'b0;
    end else begin
      rx_sync <= {rx_sync[0], rx_i};
      rx_d    <= rx_s;
      case (rx_state)
        RX_IDLE: begin
          if (ctrl[CTRL_RX_EN] & rx_d & ~rx_s) begin
            rx_state   <= RX_START;
            rx_cnt     <= '0;
            rx_div     <= div;
            rx_par     <= parity_e'(ctrl[CTRL_PAR_LSB +: 2]);
            rx_par_bad <= 1'b0;
          end
        end
        RX_START: begin
          if (rx_half) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
            if (rx_bit == 3'd7) rx_state <= parity_on(rx_par) ? RX_PARITY : RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_tick) begin
            rx_cnt     <= '0;
            rx_par_bad <= rx_par_mis;
            rx_state   <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_tick) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed bench for apb_uart_fifo: registers, TX framing, RX parity/frame/overrun, reset.
module tb_apb_uart_fifo;
  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PWRITE, PSEL, PENABLE, PREADY, PSLVERR;
  logic        rx_i, tx_o, event_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] rd;
  logic        err;

  apb_uart_fifo #(
    .ApbAddrWidth(32), .ApbDataWidth(32), .TxFifoDepth(16), .RxFifoDepth(16),
    .DefaultDiv(16'd86)
  ) dut (
    .CLK(CLK), .RST(RST), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
    .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .rx_i(rx_i), .tx_o(tx_o), .event_o(event_o)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic e);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a; PWDATA = d;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    #2 e = PSLVERR;
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
    @(posedge CLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
    @(posedge CLK); #1;
    PENABLE = 1'b1;
    #2 begin d = PRDATA; e = PSLVERR; end
    @(posedge CLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic rx_bit(input logic v);
    rx_i = v;
    repeat (10) @(posedge CLK);
  endtask

  // Serial frame at 10 cycles/bit (DIV=9); parity and stop values given explicitly.
  task automatic send_rx(input logic [7:0] b, input logic par_en, input logic par_val,
                         input logic stop);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(b[i]);
    if (par_en) rx_bit(par_val);
    rx_bit(stop);
    rx_i = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    rx_i = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;

    // Reset state
    check("rst_tx_o", tx_o, 1);
    check("rst_event", event_o, 0);
    check("rst_pslverr", PSLVERR, 0);
    check("rst_prdata", PRDATA, 0);
    check("pready", PREADY, 1);
    apb_read(32'h04, rd, err); check("rst_stat", rd, 32'h000A);
    apb_read(32'h0C, rd, err); check("rst_div", rd, 32'd86);
    apb_read(32'h14, rd, err); check("rst_rx_thr", rd, 32'h1);
    apb_read(32'h08, rd, err); check("rst_ctrl", rd, 32'h0);
    apb_read(32'h10, rd, err); check("rst_irq_en", rd, 32'h0);

    // TX frame: 0x55, no parity, one stop
    apb_write(32'h0C, 32'd9, err);
    apb_write(32'h08, 32'h01, err);
    apb_write(32'h00, 32'h55, err); check("tx_wr_err", err, 0);
    check("tx_still_idle", tx_o, 1);
    @(posedge CLK); #1;
    check("tx_start_edge", tx_o, 0);
    repeat (5) @(posedge CLK); #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("tx_bit%0d", i), tx_o, 32'(i % 2));
      repeat (10) @(posedge CLK); #1;
    end
    repeat (5) @(posedge CLK);
    apb_read(32'h04, rd, err); check("tx_done_stat", rd, 32'h000A);
    apb_write(32'h10, 32'h2, err);
    repeat (2) @(posedge CLK); #1;
    check("irq_tx_empty", event_o, 1);

    // RX with even parity, good frame, threshold IRQ
    apb_write(32'h08, 32'h07, err);
    apb_write(32'h10, 32'h1, err);
    apb_write(32'h14, 32'h2, err);
    send_rx(8'hA5, 1'b1, 1'b0, 1'b1);
    apb_read(32'h04, rd, err); check("rx_ok_stat", rd, 32'h0102);
    check("irq_thr2_off", event_o, 0);
    apb_write(32'h14, 32'h0, err);
    repeat (2) @(posedge CLK); #1;
    check("irq_thr0_on", event_o, 1);
    apb_read(32'h00, rd, err);
    check("rx_ok_data", rd, 32'hA5);
    check("rx_ok_err", err, 0);
    apb_read(32'h00, rd, err);
    check("rx_empty_err", err, 1);
    check("rx_empty_data", rd, 32'h0);

    // Parity error: byte dropped, error IRQ
    apb_write(32'h10, 32'h4, err);
    send_rx(8'hA5, 1'b1, 1'b1, 1'b1);
    apb_read(32'h04, rd, err); check("par_err_stat", rd, 32'h002A);
    check("irq_par", event_o, 1);
    apb_write(32'h04, 32'h70, err);
    apb_read(32'h04, rd, err); check("clr_stat", rd, 32'h000A);
    repeat (2) @(posedge CLK); #1;
    check("irq_cleared", event_o, 0);

    // Frame error: stop bit low
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    apb_read(32'h04, rd, err); check("frame_err_stat", rd, 32'h004A);
    apb_write(32'h04, 32'h70, err);

    // Overrun: 16 frames fill RX, 17th dropped
    apb_write(32'h08, 32'h03, err);
    for (int i = 0; i < 16; i++) send_rx(8'h30 + 8'(i), 1'b0, 1'b0, 1'b1);
    apb_read(32'h04, rd, err); check("rx_full_stat", rd, 32'h1006);
    send_rx(8'hEE, 1'b0, 1'b0, 1'b1);
    apb_read(32'h04, rd, err); check("overrun_stat", rd, 32'h1016);
    for (int i = 0; i < 16; i++) begin
      apb_read(32'h00, rd, err);
      check($sformatf("rx_fifo%0d", i), rd, 32'h30 + 32'(i));
    end
    apb_read(32'h04, rd, err); check("drained_stat", rd, 32'h001A);

    // TX full with transmitter disabled; unmapped offsets
    apb_write(32'h08, 32'h00, err);
    for (int i = 0; i < 16; i++) begin
      apb_write(32'h00, 32'hC0 + 32'(i), err);
      check($sformatf("tx_fill%0d", i), err, 0);
    end
    apb_write(32'h00, 32'hFF, err); check("tx_full_err", err, 1);
    apb_read(32'h04, rd, err); check("tx_full_stat", rd, 32'h0019);
    apb_read(32'h18, rd, err);
    check("unmapped_rd_err", err, 1);
    check("unmapped_rd_data", rd, 32'h0);
    apb_write(32'h1C, 32'hFFFF, err); check("unmapped_wr_err", err, 1);

    // Reset during an active TX frame
    apb_write(32'h08, 32'h01, err);
    repeat (20) @(posedge CLK);
    apb_read(32'h04, rd, err); check("busy_stat", rd, 32'h0098);
    #1 check("mid_frame_tx_low", tx_o, 0);
    check("pre_rst_event", event_o, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_mid_tx_o", tx_o, 1);
    check("rst_mid_event", event_o, 0);
    repeat (2) @(posedge CLK); #1;
    RST = 1'b0;
    apb_read(32'h04, rd, err); check("post_rst_stat", rd, 32'h000A);
    apb_read(32'h0C, rd, err); check("post_rst_div", rd, 32'd86);
    apb_read(32'h08, rd, err); check("post_rst_ctrl", rd, 32'h0);
    repeat (20) @(posedge CLK); #1;
    check("post_rst_tx_idle", tx_o, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
